// File: rtl/mac_operand_join_if.sv
// Operand-join handshake bundle: two independent input lanes in, one lock-step pair out.
`timescale 1ns/1ps
interface mac_operand_join_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  a_valid_i;
    logic [DATA_WIDTH-1:0] a_data_i;
    logic                  a_ready_o;
    logic                  b_valid_i;
    logic [DATA_WIDTH-1:0] b_data_i;
    logic                  b_ready_o;
    logic                  a_valid_o;
    logic [DATA_WIDTH-1:0] a_data_o;
    logic                  b_valid_o;
    logic [DATA_WIDTH-1:0] b_data_o;
    logic                  ready_i;

    modport slave (
        input  a_valid_i, a_data_i, b_valid_i, b_data_i, ready_i,
        output a_ready_o, b_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o
    );

    modport master (
        output a_valid_i, a_data_i, b_valid_i, b_data_i, ready_i,
        input  a_ready_o, b_ready_o, a_valid_o, a_data_o, b_valid_o, b_data_o
    );
endinterface

// File: rtl/mac_operand_join.sv
// Joins the a/b operand streams into lock-step pairs through per-lane FWFT FIFOs,
// counting delivered pairs against a programmed job length.
`timescale 1ns/1ps
module mac_operand_join_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   lvl_q, lvl_d;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == (AW+1)'(FIFO_DEPTH));
    // Head reads as zero while empty so the data outputs are clean after reset/clear.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            lvl_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_i) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   lvl_d = lvl_q + (AW+1)'(1);
                2'b01:   lvl_d = lvl_q - (AW+1)'(1);
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end
endmodule

module mac_operand_join #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    mac_operand_join_if.slave    io,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    localparam int NUM_LANES = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [NUM_LANES-1:0]                 in_vld, in_rdy, push, full, empty;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_data, head;
    logic                                 pair_vld, pair_hs;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;

    assign in_vld  = {io.b_valid_i, io.a_valid_i};
    assign in_data = {io.b_data_i, io.a_data_i};

    // Readiness ignores same-cycle pop: a full lane refuses even while draining.
    assign in_rdy   = {NUM_LANES{enable_i}} & ~full;
    assign push     = in_vld & in_rdy;
    assign pair_vld = enable_i & (state_q == ST_RUN) & ~|empty;
    assign pair_hs  = pair_vld & io.ready_i;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mac_operand_join_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .push_i  (push[l]),
            .data_i  (in_data[l]),
            .pop_i   (pair_hs),
            .data_o  (head[l]),
            .empty_o (empty[l]),
            .full_o  (full[l])
        );
    end

    assign io.a_ready_o = in_rdy[0];
    assign io.b_ready_o = in_rdy[1];
    assign io.a_valid_o = pair_vld;
    assign io.b_valid_o = pair_vld;
    assign io.a_data_o  = head[0];
    assign io.b_data_o  = head[1];

    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = enable_i & (state_q == ST_DONE);
    assign cnt_o   = cnt_q;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            len_d   = '0;
        end else if (enable_i) begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    len_d   = len_i;
                    cnt_d   = '0;
                    state_d = (len_i == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: if (pair_hs) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_mac_operand_join.sv
// Bench for mac_operand_join: directed scenarios plus a long random run, every cycle
// compared against a queue-based model of the join.
`timescale 1ns/1ps
module tb_mac_operand_join;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0, clear_i = 1'b0, enable_i = 1'b0, start_i = 1'b0;
    logic [CW-1:0] len_i = '0;
    logic          busy_o, done_o;
    logic [CW-1:0] cnt_o;

    mac_operand_join_if #(.DATA_WIDTH(DW)) io();

    mac_operand_join #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .start_i  (start_i),
        .len_i    (len_i),
        .io       (io),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .cnt_o    (cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [DW-1:0] qa[$], qb[$], outa[$], outb[$];
    bit  m_act, m_donep, pushed_a, pushed_b;
    int  m_cnt, m_len, done_seen, cyc, first_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        m_act = 0; m_donep = 0; m_cnt = 0; m_len = 0;
    endtask

    task automatic check_cycle();
        logic exp_v;
        exp_v = enable_i && m_act && qa.size() > 0 && qb.size() > 0;
        chk("a_valid", io.a_valid_o, exp_v);
        chk("b_valid", io.b_valid_o, exp_v);
        chk("a_ready", io.a_ready_o, enable_i && qa.size() < D);
        chk("b_ready", io.b_ready_o, enable_i && qb.size() < D);
        chk("busy", busy_o, m_act);
        chk("done", done_o, enable_i && m_donep);
        chk("cnt", cnt_o, m_cnt);
        if (qa.size() > 0) chk("a_data", io.a_data_o, qa[0]); else chk("a_data_idle", io.a_data_o, 0);
        if (qb.size() > 0) chk("b_data", io.b_data_o, qb[0]); else chk("b_data_idle", io.b_data_o, 0);
        if (io.a_valid_o && io.ready_i) begin
            outa.push_back(io.a_data_o);
            outb.push_back(io.b_data_o);
        end
        if (io.a_valid_o && first_v < 0) first_v = cyc;
        if (done_o) done_seen++;
    endtask

    // Job-level model: a running flag, pair count and a one-cycle done announcement.
    task automatic model_step();
        bit hs, pa, pb;
        pushed_a = 0; pushed_b = 0;
        if (!rst_ni || clear_i) begin
            model_reset();
            return;
        end
        if (!enable_i) return;
        hs = m_act && qa.size() > 0 && qb.size() > 0 && io.ready_i;
        pa = io.a_valid_i && qa.size() < D;
        pb = io.b_valid_i && qb.size() < D;
        if (hs) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        if (pa) begin qa.push_back(io.a_data_i); pushed_a = 1; end
        if (pb) begin qb.push_back(io.b_data_i); pushed_b = 1; end
        if (m_donep) m_donep = 0;
        else if (m_act) begin
            if (hs) begin
                m_cnt++;
                if (m_cnt == m_len) begin m_act = 0; m_donep = 1; end
            end
        end else if (start_i) begin
            m_len = len_i; m_cnt = 0;
            if (len_i == 0) m_donep = 1; else m_act = 1;
        end
    endtask

    task automatic tick();
        #3;
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_in();
        io.a_valid_i = 0; io.b_valid_i = 0; start_i = 0;
    endtask

    task automatic new_job();
        outa.delete(); outb.delete(); done_seen = 0; first_v = -1;
    endtask

    initial begin
        int na, nb, c0, g;
        cyc = 0; first_v = -1; done_seen = 0;
        io.a_valid_i = 0; io.b_valid_i = 0; io.a_data_i = '0; io.b_data_i = '0; io.ready_i = 0;
        model_reset();
        tick(); tick();
        rst_ni = 1; enable_i = 1;
        tick();

        // Directed: a back-to-back, b two cycles late.
        new_job(); c0 = cyc;
        for (int c = 0; c < 12; c++) begin
            start_i = (c == 0); len_i = 4; io.ready_i = 1;
            io.a_valid_i = (c < 4);            io.a_data_i = c + 1;
            io.b_valid_i = (c >= 2 && c < 6); io.b_data_i = (c - 1) * 10;
            tick();
        end
        idle_in();
        chk("t1_pairs", outa.size(), 4);
        for (int i = 0; i < 4 && i < outa.size(); i++) begin
            chk("t1_a", outa[i], i + 1);
            chk("t1_b", outb[i], (i + 1) * 10);
        end
        chk("t1_first_valid", first_v - c0, 3);
        chk("t1_done_cnt", done_seen, 1);
        chk("t1_final_cnt", cnt_o, 4);

        // Consumer stall with both lanes fed.
        new_job(); na = 0; nb = 0;
        for (int c = 0; c < 22; c++) begin
            start_i = (c == 0); len_i = 8; io.ready_i = (c >= 6);
            io.a_valid_i = (na < 8); io.a_data_i = 100 + na;
            io.b_valid_i = (nb < 8); io.b_data_i = 200 + nb;
            if (c == 5) chk("t2_a_ready_full", io.a_ready_o, 0);
            tick();
            if (pushed_a) na++;
            if (pushed_b) nb++;
        end
        idle_in();
        chk("t2_pairs", outa.size(), 8);
        for (int i = 0; i < 8 && i < outa.size(); i++) begin
            chk("t2_a", outa[i], 100 + i);
            chk("t2_b", outb[i], 200 + i);
        end
        chk("t2_done_cnt", done_seen, 1);

        // Prefetch in IDLE, then start.
        new_job();
        for (int c = 0; c < 3; c++) begin
            io.a_valid_i = 1; io.a_data_i = 300 + c;
            io.b_valid_i = 1; io.b_data_i = 400 + c;
            tick();
        end
        idle_in();
        start_i = 1; len_i = 3; io.ready_i = 1; c0 = cyc;
        tick();
        start_i = 0;
        for (int c = 0; c < 6; c++) tick();
        chk("t3_first_valid", first_v - c0, 1);
        chk("t3_pairs", outa.size(), 3);
        chk("t3_done_cnt", done_seen, 1);

        // Zero-length job leaves queued data alone.
        new_job();
        io.a_valid_i = 1; io.a_data_i = 500; io.b_valid_i = 1; io.b_data_i = 600;
        tick();
        idle_in();
        start_i = 1; len_i = 0;
        tick();
        start_i = 0;
        for (int c = 0; c < 4; c++) tick();
        chk("t4_no_pairs", outa.size(), 0);
        chk("t4_done_cnt", done_seen, 1);
        chk("t4_head_a", io.a_data_o, 500);
        chk("t4_head_b", io.b_data_o, 600);
        clear_i = 1; tick(); clear_i = 0;

        // Clear, then async reset, at cnt=2 of 8.
        for (int pass = 0; pass < 2; pass++) begin
            new_job(); na = 0; g = 0;
            start_i = 1; len_i = 8; io.ready_i = 1;
            while (g < 30 && cnt_o != 2) begin
                io.a_valid_i = 1; io.a_data_i = 700 + na;
                io.b_valid_i = 1; io.b_data_i = 800 + na;
                tick(); start_i = 0; g++;
                if (pushed_a) na++;
            end
            chk("t5_reach_cnt2", cnt_o, 2);
            idle_in(); done_seen = 0;
            if (pass == 0) begin
                clear_i = 1; tick(); clear_i = 0;
            end else begin
                rst_ni = 0; model_reset(); tick(); rst_ni = 1;
            end
            chk("t5_cnt_zero", cnt_o, 0);
            chk("t5_busy_zero", busy_o, 0);
            chk("t5_a_empty_data", io.a_data_o, 0);
            for (int c = 0; c < 3; c++) tick();
            chk("t5_no_done", done_seen, 0);
        end

        // Random traffic over a 1000-pair job.
        new_job(); g = 0;
        start_i = 1; len_i = 1000; enable_i = 1;
        while (g < 20000 && done_seen == 0) begin
            io.a_valid_i = ($urandom % 4) != 0; io.a_data_i = $urandom;
            io.b_valid_i = ($urandom % 3) != 0; io.b_data_i = $urandom;
            io.ready_i   = $urandom % 2;
            tick(); g++;
            start_i  = ($urandom % 64) == 0;
            enable_i = ($urandom % 10) != 0;
        end
        idle_in(); enable_i = 1;
        chk("t6_done_seen", done_seen, 1);
        chk("t6_pairs", outa.size(), 1000);
        chk("t6_final_cnt", cnt_o, 1000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
